// File: rtl/reservation_station_if.sv
// Dispatch, CDB snoop and issue bundle for the reservation station.
// The master drives dispatch/CDB/issue_ready; the slave is the station itself.
interface reservation_station_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [82:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             issue_valid;
    logic             issue_ready;
    logic [31:0]      issue_op1;
    logic [31:0]      issue_op2;
    logic [4:0]       issue_rd;
    logic [11:0]      issue_ctrl;
    logic [TAG_W-1:0] issue_tag;
    logic [CW-1:0]    count;

    modport master (
        output flush, in_valid, in_inst, in_tag, cdb_valid, cdb_tag, cdb_value, issue_ready,
        input  in_ready, issue_valid, issue_op1, issue_op2, issue_rd, issue_ctrl, issue_tag, count
    );

    modport slave (
        input  flush, in_valid, in_inst, in_tag, cdb_valid, cdb_tag, cdb_value, issue_ready,
        output in_ready, issue_valid, issue_op1, issue_op2, issue_rd, issue_ctrl, issue_tag, count
    );
endinterface

// File: rtl/reservation_station.sv
// DEPTH-entry reservation station: buffers dispatched ops, snoops the CDB, issues oldest ready.
// Optional macro RS_DISPATCH_BYPASS_EN: capture a same-cycle CDB result at dispatch instead of stalling.
module reservation_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    reservation_station_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] AGE_MAX = AW'(DEPTH - 1);

    typedef struct packed {
        logic             busy;
        logic             v1;
        logic [31:0]      val1;
        logic             v2;
        logic [31:0]      val2;
        logic [4:0]       rd;
        logic [11:0]      ctrl;
        logic [TAG_W-1:0] tag;
        logic [AW-1:0]    age;
    } entry_t;

    entry_t        ent [DEPTH];
    logic [CW-1:0] count_q;

    entry_t        new_ent;
    logic [AW-1:0] alloc_idx;
    logic [AW-1:0] sel_idx;
    logic [AW-1:0] sel_age;
    logic          sel_valid;
    logic          space_avail;
    logic          disp_fire;
    logic          issue_fire;

    assign space_avail = (count_q < CW'(DEPTH));
`ifdef RS_DISPATCH_BYPASS_EN
    assign bus.in_ready = space_avail;
`else
    // Without the bypass a broadcast could slip past the entry being written, so stall.
    assign bus.in_ready = space_avail && !bus.cdb_valid;
`endif
    assign disp_fire  = bus.in_valid && bus.in_ready;
    assign issue_fire = sel_valid && bus.issue_ready;

    // Decode incoming instruction into a fresh entry
    always_comb begin
        new_ent      = '0;
        new_ent.busy = 1'b1;
        new_ent.val2 = bus.in_inst[82:51];
        new_ent.v2   = bus.in_inst[50];
        new_ent.val1 = bus.in_inst[49:18];
        new_ent.v1   = bus.in_inst[17];
        new_ent.rd   = bus.in_inst[16:12];
        new_ent.ctrl = bus.in_inst[11:0];
        new_ent.tag  = bus.in_tag;
        new_ent.age  = '0;
`ifdef RS_DISPATCH_BYPASS_EN
        if (bus.cdb_valid && !new_ent.v1 && (new_ent.val1[TAG_W-1:0] == bus.cdb_tag)) begin
            new_ent.val1 = bus.cdb_value;
            new_ent.v1   = 1'b1;
        end
        if (bus.cdb_valid && !new_ent.v2 && (new_ent.val2[TAG_W-1:0] == bus.cdb_tag)) begin
            new_ent.val2 = bus.cdb_value;
            new_ent.v2   = 1'b1;
        end
`endif
    end

    // Lowest free slot for allocation
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent[i].busy) alloc_idx = AW'(i);
        end
    end

    // Oldest ready entry; ties (only possible after age saturation) go to the lowest index
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].busy && ent[i].v1 && ent[i].v2 && (!sel_valid || (ent[i].age > sel_age))) begin
                sel_valid = 1'b1;
                sel_idx   = AW'(i);
                sel_age   = ent[i].age;
            end
        end
    end

    assign bus.issue_valid = sel_valid;
    assign bus.issue_op1   = sel_valid ? ent[sel_idx].val1 : '0;
    assign bus.issue_op2   = sel_valid ? ent[sel_idx].val2 : '0;
    assign bus.issue_rd    = sel_valid ? ent[sel_idx].rd   : '0;
    assign bus.issue_ctrl  = sel_valid ? ent[sel_idx].ctrl : '0;
    assign bus.issue_tag   = sel_valid ? ent[sel_idx].tag  : '0;
    assign bus.count       = count_q;

    // Entry state: wakeup, aging, issue release and allocation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent[i].busy) begin
                    if (bus.cdb_valid && !ent[i].v1 && (ent[i].val1[TAG_W-1:0] == bus.cdb_tag)) begin
                        ent[i].val1 <= bus.cdb_value;
                        ent[i].v1   <= 1'b1;
                    end
                    if (bus.cdb_valid && !ent[i].v2 && (ent[i].val2[TAG_W-1:0] == bus.cdb_tag)) begin
                        ent[i].val2 <= bus.cdb_value;
                        ent[i].v2   <= 1'b1;
                    end
                    if (disp_fire && (ent[i].age != AGE_MAX)) ent[i].age <= ent[i].age + AW'(1);
                end
                if (issue_fire && (sel_idx == AW'(i))) ent[i].busy <= 1'b0;
                if (disp_fire && (alloc_idx == AW'(i))) ent[i] <= new_ent;
            end
            count_q <= count_q + CW'(disp_fire) - CW'(issue_fire);
        end
    end
endmodule
